stream_sink: RTL

STREAM_SINK -- requirements
Module: stream_sink

---
 rtl/stream_sink.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/stream_sink.sv
// stream_sink: FIFO-buffered stream sink with a sequence checker.
// Words are accepted from a valid/ready source into a DEPTH-entry FIFO,
// then popped either under drain_en (RUN) or unconditionally (FLUSH).
// Each popped word is compared against the expected running sequence.
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
module stream_sink #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk1,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             drain_en,
    input  logic             flush,
    output logic [15:0]      rx_count,
    output logic [15:0]      err_count,
    output logic [WIDTH-1:0] last_data,
    output logic             empty,
    output logic             full,
    output logic             busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);
    localparam logic [15:0] CNT_MAX  = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      occ;
    logic [AW:0]      occ_next;
    logic [WIDTH-1:0] exp;

    logic             push;
    logic             pop;
    logic             flush_done;
    logic [WIDTH-1:0] pop_data;

    // Occupancy flags come straight from the registered counter.
    assign empty    = (occ == '0);
    assign full     = (occ == OCC_FULL);
    assign pop_data = mem[rd_ptr];

    // State register.
    // NOTE: sequential blocks use non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Handshake, pop qualification, occupancy update and next-state logic.
    // NOTE: every signal gets a default at the top of the block so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        in_ready   = !full && (state != FLUSH);
        busy       = (state != IDLE);
        push       = in_valid && in_ready;
        pop        = !empty && (((state == RUN) && drain_en) || (state == FLUSH));
        occ_next   = occ;
        flush_done = 1'b0;

        unique case ({push, pop})
            2'b10:   occ_next = occ + (AW+1)'(1);
            2'b01:   occ_next = occ - (AW+1)'(1);
            default: occ_next = occ;
        endcase

        unique case (state)
            IDLE: begin
                // flush is deliberately ignored here; only an accepted word starts RUN.
                if (push) state_next = RUN;
            end
            RUN: begin
                if (flush) state_next = FLUSH;
            end
            FLUSH: begin
                // No pushes happen in FLUSH, so occupancy only falls toward empty.
                if (occ_next == '0) begin
                    state_next = IDLE;
                    flush_done = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FIFO storage write port.
    // NOTE: the storage array is intentionally not reset; resetting the
    // pointers and occupancy is enough to discard its contents.
    always_ff @(posedge clk1) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    // Pointers and occupancy counter; pointers wrap modulo DEPTH.
    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            occ <= occ_next;
        end
    end

    // Accepted-word counter, saturating.
    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            rx_count <= '0;
        end else if (push && (rx_count != CNT_MAX)) begin
            rx_count <= rx_count + 16'd1;
        end
    end

    // Sequence checker: compare each popped word with exp, then resync to
    // popped+1. Leaving FLUSH restarts the sequence at 0, overriding the pop.
    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            exp       <= '0;
            err_count <= '0;
            last_data <= '0;
        end else begin
            if (pop) begin
                last_data <= pop_data;
                if ((pop_data != exp) && (err_count != CNT_MAX)) begin
                    err_count <= err_count + 16'd1;
                end
            end
            if (flush_done) begin
                exp <= '0;
            end else if (pop) begin
                exp <= pop_data + WIDTH'(1);
            end
        end
    end

endmodule
